// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : div_pkg
//  Description : Shared FSM encoding and default widths for iter_divider.
//  Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

  localparam int DIV_DW = 14;
  localparam int DIV_VW = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } div_state_e;

endpackage : div_pkg
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
//  Module      : div_step
//  Description : One restoring shift-subtract step on a VW+1-bit partial
//                remainder; emits the quotient bit and the next remainder.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_step
  import div_pkg::*;
#(
  parameter int VW = DIV_VW
) (
  input  logic [VW-1:0] rem_in,
  input  logic          bit_in,
  input  logic [VW-1:0] divisor,
  output logic [VW-1:0] rem_out,
  output logic          q_bit
);

  logic [VW:0] w_shift;
  logic [VW:0] w_diff;
  logic [VW:0] w_res;
  logic        w_unused;

  always_comb begin
    w_shift = {rem_in, bit_in};
    w_diff  = w_shift - {1'b0, divisor};
    q_bit   = (w_shift >= {1'b0, divisor});
    w_res   = q_bit ? w_diff : w_shift;
  end

  // The result is always below the divisor, so its top bit is always zero.
  assign rem_out  = w_res[VW-1:0];
  assign w_unused = w_res[VW];

endmodule : div_step
`default_nettype wire

// File: rtl/iter_divider.sv
`default_nettype none
// ============================================================================
//  Module      : iter_divider
//  Description : Iterative restoring divider, signed/unsigned, one quotient
//                bit per cycle, with divide-by-zero and overflow flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module iter_divider
  import div_pkg::*;
#(
  parameter int DW = DIV_DW,
  parameter int VW = DIV_VW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          sgn,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  input  logic          abort,
  output logic          ready,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          dbz,
  output logic          ovf
);

  localparam int            c_cnt_w   = $clog2(DW);
  localparam logic [DW-1:0] c_dvd_min = {1'b1, {(DW-1){1'b0}}};

  div_state_e r_state;
  div_state_e w_state_nxt;

  logic [DW-1:0]      r_quo;
  logic [VW-1:0]      r_rem;
  logic [VW-1:0]      r_div;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_ovf_p;
  logic               r_dbz_p;

  logic               r_done;
  logic [DW-1:0]      r_quotient;
  logic [VW-1:0]      r_remainder;
  logic               r_dbz;
  logic               r_ovf;

  logic               w_capture;
  logic               w_last;
  logic               w_dvd_neg;
  logic               w_dvs_neg;
  logic               w_dvs_zero;
  logic               w_ovf;
  logic [DW-1:0]      w_abs_dvd;
  logic [VW-1:0]      w_abs_dvs;
  logic [VW-1:0]      w_rem_nxt;
  logic               w_qbit;

  assign w_capture  = (r_state == IDLE) && start;
  assign w_last     = (r_cnt == c_cnt_w'(DW-1));
  assign w_dvd_neg  = sgn & dividend[DW-1];
  assign w_dvs_neg  = sgn & divisor[VW-1];
  assign w_dvs_zero = (divisor == '0);
  assign w_ovf      = sgn && (dividend == c_dvd_min) && (divisor == '1);
  assign w_abs_dvd  = w_dvd_neg ? (DW'(0) - dividend) : dividend;
  assign w_abs_dvs  = w_dvs_neg ? (VW'(0) - divisor) : divisor;

  div_step #(
    .VW (VW)
  ) u_step (
    .rem_in  (r_rem),
    .bit_in  (r_quo[DW-1]),
    .divisor (r_div),
    .rem_out (w_rem_nxt),
    .q_bit   (w_qbit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // A zero divisor bypasses RUN; FIX then publishes the fixed dbz result.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = w_dvs_zero ? FIX : RUN;
      RUN: begin
        if (abort)       w_state_nxt = IDLE;
        else if (w_last) w_state_nxt = FIX;
      end
      FIX:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // r_quo starts as the dividend magnitude and fills with quotient bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_quo   <= '0;
      r_rem   <= '0;
      r_div   <= '0;
      r_cnt   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_ovf_p <= 1'b0;
      r_dbz_p <= 1'b0;
    end else if (w_capture) begin
      r_quo   <= w_abs_dvd;
      r_rem   <= '0;
      r_div   <= w_abs_dvs;
      r_cnt   <= '0;
      r_neg_q <= w_dvd_neg ^ w_dvs_neg;
      r_neg_r <= w_dvd_neg;
      r_ovf_p <= w_ovf;
      r_dbz_p <= w_dvs_zero;
    end else if ((r_state == RUN) && !abort) begin
      r_quo   <= {r_quo[DW-2:0], w_qbit};
      r_rem   <= w_rem_nxt;
      r_cnt   <= r_cnt + c_cnt_w'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_done      <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if ((r_state == FIX) && !abort) begin
        r_done <= 1'b1;
        if (r_dbz_p) begin
          r_quotient  <= '1;
          r_remainder <= '0;
          r_dbz       <= 1'b1;
          r_ovf       <= 1'b0;
        end else begin
          r_quotient  <= r_neg_q ? (DW'(0) - r_quo) : r_quo;
          r_remainder <= r_neg_r ? (VW'(0) - r_rem) : r_rem;
          r_dbz       <= 1'b0;
          r_ovf       <= r_ovf_p;
        end
      end
    end
  end

  assign ready     = (r_state == IDLE);
  assign done      = r_done;
  assign quotient  = r_quotient;
  assign remainder = r_remainder;
  assign dbz       = r_dbz;
  assign ovf       = r_ovf;

endmodule : iter_divider
`default_nettype wire

// File: tb/tb_iter_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_iter_divider
//  Description : Directed self-checking bench for iter_divider (DW=14, VW=10).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_iter_divider;

  localparam int DW = 14;
  localparam int VW = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          sgn;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          abort;
  logic          ready;
  logic          done;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          dbz;
  logic          ovf;

  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;

  iter_divider #(
    .DW (DW),
    .VW (VW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .sgn       (sgn),
    .dividend  (dividend),
    .divisor   (divisor),
    .abort     (abort),
    .ready     (ready),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .dbz       (dbz),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) n_done++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start one operation and measure edges from capture (edge 1) to done.
  task automatic run_op(input string tag, input logic s, input logic [DW-1:0] a,
                        input logic [VW-1:0] b, input logic ab,
                        input logic [DW-1:0] eq, input logic [VW-1:0] er,
                        input logic edbz, input logic eovf, input int elat);
    int  lat;
    chk({tag, "_ready"}, ready, 1);
    sgn = s; dividend = a; divisor = b; start = 1'b1; abort = ab;
    tick();
    start = 1'b0; abort = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
    chk({tag, "_lat"}, lat, elat);
    chk({tag, "_q"},   quotient, eq);
    chk({tag, "_r"},   remainder, er);
    chk({tag, "_dbz"}, dbz, edbz);
    chk({tag, "_ovf"}, ovf, eovf);
    tick();
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_q_hold"}, quotient, eq);
  endtask

  initial begin
    int saved;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; sgn = 1'b0;
    dividend = '0; divisor = '0;
    repeat (3) tick();
    chk("rst_ready", ready, 1);
    chk("rst_done",  done, 0);
    chk("rst_q",     quotient, 0);
    chk("rst_r",     remainder, 0);
    chk("rst_flags", {dbz, ovf}, 0);
    rst_n = 1'b1;
    tick();

    run_op("u9999_7",   0, 14'd9999,  10'd7,     0, 14'd1428,  10'd3,     0, 0, 16);
    run_op("s-100_7",   1, 14'h3F9C,  10'd7,     0, 14'h3FF2,  10'h3FE,   0, 0, 16);
    run_op("dbz",       0, 14'd1234,  10'd0,     0, 14'h3FFF,  10'd0,     1, 0, 2);
    run_op("ovf",       1, 14'h2000,  10'h3FF,   0, 14'h2000,  10'd0,     0, 1, 16);
    run_op("s100_-7",   1, 14'd100,   10'h3F9,   0, 14'h3FF2,  10'd2,     0, 0, 16);
    run_op("s-100_-7",  1, 14'h3F9C,  10'h3F9,   0, 14'd14,    10'h3FE,   0, 0, 16);
    run_op("umax_abst", 0, 14'h3FFF,  10'h3FF,   1, 14'd16,    10'd15,    0, 0, 16);

    // Busy re-start is ignored and abort cancels without a done.
    saved = n_done;
    sgn = 1'b0; dividend = 14'd100; divisor = 10'd3; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk("busy_ready", ready, 0);
    dividend = 14'd50; divisor = 10'd5; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_ready", ready, 1);
    repeat (20) tick();
    chk("abort_no_done", n_done, saved);
    chk("abort_q_hold",  quotient, 14'd16);
    chk("abort_r_hold",  remainder, 10'd15);

    run_op("u50_5",     0, 14'd50,    10'd5,     0, 14'd10,    10'd0,     0, 0, 16);
    run_op("u5_9",      0, 14'd5,     10'd9,     0, 14'd0,     10'd5,     0, 0, 16);
    run_op("s-5_9",     1, 14'h3FFB,  10'd9,     0, 14'd0,     10'h3FB,   0, 0, 16);
    run_op("sdbz",      1, 14'h3FFD,  10'd0,     0, 14'h3FFF,  10'd0,     1, 0, 2);

    // Reset in the middle of RUN discards the operation.
    saved = n_done;
    sgn = 1'b0; dividend = 14'd9999; divisor = 10'd7; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mrst_ready", ready, 1);
    chk("mrst_q",     quotient, 0);
    chk("mrst_r",     remainder, 0);
    chk("mrst_flags", {done, dbz, ovf}, 0);
    repeat (20) tick();
    chk("mrst_no_done", n_done, saved);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule : tb_iter_divider
`default_nettype wire
